// File: rtl/pipe_pkg.sv
// Shared defaults and helpers for the elastic pipeline register.
// Optional flush support is enabled with the PIPE_REG_FLUSH_EN macro.
package pipe_pkg;

  localparam int PIPE_WIDTH_DEF  = 8;
  localparam int PIPE_STAGES_DEF = 2;

  // Bits needed to hold values 0..value-1; usable in constant expressions.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) begin
        result = i + 1;
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/pipe_stage.sv
// One elastic pipeline slot: a valid flag plus a data word.
// Data is only written when a valid word arrives, so bubbles never toggle it.
module pipe_stage #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic             i_clear,
  input  logic             i_valid,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data
);

  logic             r_valid;
  logic [WIDTH-1:0] r_data;

  // Clear drops the word but keeps the data register untouched.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (i_clear) begin
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_valid <= i_valid;
      if (i_valid) begin
        r_data <= i_data;
      end
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;

endmodule

// File: rtl/pipe_reg_elastic.sv
// Elastic STAGES-deep pipeline register with valid/ready handshake, stall and bubble collapsing.
// Define PIPE_REG_FLUSH_EN to add the flush port that empties the pipe in one edge.
module pipe_reg_elastic
  import pipe_pkg::*;
#(
  parameter int WIDTH  = PIPE_WIDTH_DEF,
  parameter int STAGES = PIPE_STAGES_DEF
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [WIDTH-1:0]             in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [WIDTH-1:0]             out_data,
  output logic [clog2(STAGES+1)-1:0]   count
`ifdef PIPE_REG_FLUSH_EN
  ,
  input  logic                         flush
`endif
);

  localparam int CW = clog2(STAGES + 1);

  logic [STAGES-1:0] w_valid;
  logic [STAGES-1:0] w_load;
  logic [WIDTH-1:0]  w_data [STAGES];
  logic              w_flush;
  logic              w_push;
  logic              w_pop;
  logic [CW-1:0]     r_count;

`ifdef PIPE_REG_FLUSH_EN
  assign w_flush = flush;
`else
  assign w_flush = 1'b0;
`endif

  // A stage loads when enabled and either the consumer accepts or some slot at or
  // beyond it is empty; this folds the advance chain and bubble collapsing into one term.
  always_comb begin : loadChain
    logic full;
    full   = 1'b1;
    w_load = '0;
    for (int k = STAGES - 1; k >= 0; k--) begin
      full      = full & w_valid[k];
      w_load[k] = en & (out_ready | ~full);
    end
  end

  assign in_ready = ~rst & ~w_flush & w_load[0];
  assign w_push   = in_valid & in_ready;
  assign w_pop    = w_valid[STAGES-1] & w_load[STAGES-1];

  for (genvar k = 0; k < STAGES; k++) begin : gStage
    logic             w_prevValid;
    logic [WIDTH-1:0] w_prevData;

    if (k == 0) begin : gHead
      assign w_prevValid = in_valid;
      assign w_prevData  = in_data;
    end else begin : gBody
      assign w_prevValid = w_valid[k-1];
      assign w_prevData  = w_data[k-1];
    end

    pipe_stage #(
      .WIDTH(WIDTH)
    ) uStage (
      .clk    (clk),
      .rst    (rst),
      .i_load (w_load[k]),
      .i_clear(w_flush),
      .i_valid(w_prevValid),
      .i_data (w_prevData),
      .o_valid(w_valid[k]),
      .o_data (w_data[k])
    );
  end

  // Occupancy tracks pushes and pops directly rather than summing the valid flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (w_flush) begin
      r_count <= '0;
    end else begin
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign out_valid = w_valid[STAGES-1];
  assign out_data  = w_data[STAGES-1];
  assign count     = r_count;

endmodule

// File: tb/tb_pipe_reg_elastic.sv
// Self-checking bench for pipe_reg_elastic: two instances (2 and 3 stages) share one stimulus
// stream; each has a word-level scoreboard. Build with PIPE_REG_FLUSH_EN to exercise flush.
module tb_pipe_reg_elastic;

  typedef struct {
    logic [7:0] data;
    int         age;
  } entry_t;

  logic       clk;
  logic       rst;
  logic       en;
  logic       inValid;
  logic [7:0] inData;
  logic       outReady;
  logic       flush;

  int checks;
  int errors;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Flush only takes effect in builds where the port exists.
  function automatic logic flushActive();
`ifdef PIPE_REG_FLUSH_EN
    return flush;
`else
    return 1'b0;
`endif
  endfunction

  task automatic checkOutput(input int lane, input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("[TB] FAIL lane%0d %s: got %0h, expected %0h (t=%0t)", lane, name, got, want, $time);
    end
  endtask

  // Inputs change on the falling edge, well away from the sampling rising edge.
  task automatic applyStimulus(input logic r, input logic e, input logic v,
                               input logic [7:0] d, input logic o, input logic f);
    @(negedge clk);
    rst      = r;
    en       = e;
    inValid  = v;
    inData   = d;
    outReady = o;
    flush    = f;
  endtask

  task automatic idle(input int n, input logic o);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b1, 1'b0, 8'h00, o, 1'b0);
  endtask

  for (genvar g = 0; g < 2; g++) begin : gLane
    localparam int S = 2 + g;

    logic       laneInReady;
    logic       laneOutValid;
    logic [7:0] laneOutData;
    logic [1:0] laneCount;

    entry_t sbQueue[$];
    int     preSize;

    pipe_reg_elastic #(
      .WIDTH (8),
      .STAGES(S)
    ) dut (
      .clk      (clk),
      .rst      (rst),
      .en       (en),
      .in_valid (inValid),
      .in_ready (laneInReady),
      .in_data  (inData),
      .out_valid(laneOutValid),
      .out_ready(outReady),
      .out_data (laneOutData),
      .count    (laneCount)
`ifdef PIPE_REG_FLUSH_EN
      ,
      .flush    (flush)
`endif
    );

    // Output side: a word is visible once it has seen S enabled edges since entry;
    // it leaves at an edge where the consumer accepts while enabled.
    initial begin : monitor
      bit     expValid;
      entry_t head;
      preSize = 0;
      forever begin
        @(negedge clk);
        #3;
        if (rst) begin
          checkOutput(g, "outValidReset", int'(laneOutValid), 0);
          checkOutput(g, "outDataReset", int'(laneOutData), 0);
          checkOutput(g, "countReset", int'(laneCount), 0);
          sbQueue.delete();
          preSize = 0;
        end else begin
          expValid = (sbQueue.size() > 0) && (sbQueue[0].age >= S);
          checkOutput(g, "outValid", int'(laneOutValid), int'(expValid));
          if (expValid) begin
            checkOutput(g, "outData", int'(laneOutData), int'(sbQueue[0].data));
          end
          checkOutput(g, "count", int'(laneCount), sbQueue.size());
          preSize = sbQueue.size();
          if (flushActive()) begin
            sbQueue.delete();
          end else if (en) begin
            if (expValid && outReady) begin
              head = sbQueue.pop_front();
            end
            foreach (sbQueue[i]) sbQueue[i].age++;
          end
        end
      end
    end

    // Input side: the pipe refuses input only when stalled, flushing, in reset,
    // or holding S words with no pop this cycle.
    initial begin : driverModel
      bit expReady;
      forever begin
        @(negedge clk);
        #4;
        expReady = !rst && !flushActive() && en && ((preSize < S) || outReady);
        checkOutput(g, "inReady", int'(laneInReady), int'(expReady));
        if (!rst && inValid && expReady) begin
          sbQueue.push_back('{data: inData, age: 1});
        end
      end
    end
  end

  initial begin
    checks   = 0;
    errors   = 0;
    rst      = 1'b1;
    en       = 1'b1;
    inValid  = 1'b0;
    inData   = 8'h00;
    outReady = 1'b1;
    flush    = 1'b0;

    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
    idle(2, 1'b1);

    $display("[TB] back-to-back stream");
    applyStimulus(1'b0, 1'b1, 1'b1, 8'h11, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b1, 8'h22, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b1, 8'h33, 1'b1, 1'b0);
    idle(5, 1'b1);

    $display("[TB] backpressure");
    applyStimulus(1'b0, 1'b1, 1'b1, 8'hA5, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b1, 8'h5A, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b1, 8'hFF, 1'b1, 1'b0);
    idle(5, 1'b1);

    $display("[TB] bubble collapse");
    applyStimulus(1'b0, 1'b1, 1'b1, 8'h7E, 1'b0, 1'b0);
    idle(3, 1'b0);
    for (int i = 1; i <= 3; i++) applyStimulus(1'b0, 1'b1, 1'b1, 8'(i), 1'b0, 1'b0);
    idle(5, 1'b1);

    $display("[TB] global enable stall");
    applyStimulus(1'b0, 1'b1, 1'b1, 8'hC1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b1, 8'hC2, 1'b0, 1'b0);
    idle(1, 1'b0);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0, 1'b1, 8'hEE, 1'b1, 1'b0);
    idle(5, 1'b1);

    $display("[TB] reset mid-stream");
    applyStimulus(1'b0, 1'b1, 1'b1, 8'h91, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b1, 8'h92, 1'b0, 1'b0);
    idle(1, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b1, 8'h93, 1'b1, 1'b0);
    idle(4, 1'b1);

`ifdef PIPE_REG_FLUSH_EN
    $display("[TB] flush");
    applyStimulus(1'b0, 1'b1, 1'b1, 8'hB1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b1, 8'hB2, 1'b0, 1'b0);
    idle(1, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b1, 8'h44, 1'b1, 1'b1);
    idle(4, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b1, 8'hB3, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    idle(4, 1'b1);
`endif

    $display("[TB] randomized traffic");
    for (int i = 0; i < 3000; i++) begin
      applyStimulus(1'($urandom_range(0, 99) == 0),
                    1'($urandom_range(0, 99) < 85),
                    1'($urandom_range(0, 99) < 70),
                    8'($urandom_range(0, 255)),
                    1'($urandom_range(0, 99) < 60),
                    1'($urandom_range(0, 99) < 3));
    end
    idle(8, 1'b1);

    @(negedge clk);
    #6;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
